// File: rtl/memory_controller_q_if.sv
// Request/completion bus of memory_controller_q: write and read request channels in,
// address-tagged completions out.
interface memory_controller_q_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_ret_address;
    logic              wr_ret_ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_ret_data;
    logic [ADDR_W-1:0] rd_ret_address;
    logic              rd_ret_ack;
    logic              busy;

    modport master (
        output wr_en, wr_address, wr_data, rd_en, rd_address,
        input  wr_ready, wr_ret_address, wr_ret_ack,
        input  rd_ready, rd_ret_data, rd_ret_address, rd_ret_ack, busy
    );

    modport slave (
        input  wr_en, wr_address, wr_data, rd_en, rd_address,
        output wr_ready, wr_ret_address, wr_ret_ack,
        output rd_ready, rd_ret_data, rd_ret_address, rd_ret_ack, busy
    );
endinterface

// File: rtl/memory_controller_q.sv
// Queued fixed-latency single-port memory: per-channel request FIFOs, a read-first
// arbiter with RAW protection, and a LATENCY-deep completion pipeline.
module memory_controller_q #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_AW  = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 4
) (
    input logic                  clk,
    input logic                  reset,
    memory_controller_q_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              is_wr;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [ADDR_W-1:0] wq_addr [DEPTH];
    logic [DATA_W-1:0] wq_data [DEPTH];
    logic [ADDR_W-1:0] rq_addr [DEPTH];
    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic [PW-1:0] wq_head_q, wq_head_d, wq_tail_q, wq_tail_d;
    logic [PW-1:0] rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;
    logic [CW-1:0] wq_count_q, wq_count_d, rq_count_q, rq_count_d;
    stage_t        pipe_q [LATENCY];
    stage_t        pipe_d [LATENCY];

    logic              wr_ret_ack_q, wr_ret_ack_d, rd_ret_ack_q, rd_ret_ack_d;
    logic [ADDR_W-1:0] wr_ret_address_q, wr_ret_address_d;
    logic [ADDR_W-1:0] rd_ret_address_q, rd_ret_address_d;
    logic [DATA_W-1:0] rd_ret_data_q, rd_ret_data_d;

    logic          wr_ready, rd_ready, wr_push, rd_push, wr_pop, rd_pop;
    logic          wr_nonempty, rd_nonempty, hazard, any_valid;
    logic [PW-1:0] wq_offset [DEPTH];
    logic          wq_live [DEPTH];
    stage_t        last;
    logic [MEM_AW-1:0] last_idx;

    // A write-FIFO slot is live when it lies within count entries of the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wq_offset[i] = PW'(i) - wq_head_q;
            wq_live[i]   = {1'b0, wq_offset[i]} < wq_count_q;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        wr_ready    = wq_count_q != FULL;
        rd_ready    = rq_count_q != FULL;
        wr_push     = bus.wr_en && wr_ready;
        rd_push     = bus.rd_en && rd_ready;
        wr_nonempty = wq_count_q != '0;
        rd_nonempty = rq_count_q != '0;

        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wq_live[i] && wq_addr[i][MEM_AW-1:0] == rq_addr[rq_head_q][MEM_AW-1:0]) begin
                hazard = 1'b1;
            end
        end

        // Reads win unless the write FIFO is full or the read would overtake a pending write.
        wr_pop = wr_nonempty && (!rd_nonempty || !wr_ready || hazard);
        rd_pop = rd_nonempty && !wr_pop;

        wq_tail_d  = wq_tail_q + PW'(wr_push);
        wq_head_d  = wq_head_q + PW'(wr_pop);
        wq_count_d = wq_count_q + CW'(wr_push) - CW'(wr_pop);
        rq_tail_d  = rq_tail_q + PW'(rd_push);
        rq_head_d  = rq_head_q + PW'(rd_pop);
        rq_count_d = rq_count_q + CW'(rd_push) - CW'(rd_pop);

        pipe_d[0] = '0;
        if (wr_pop) begin
            pipe_d[0] = '{1'b1, 1'b1, wq_addr[wq_head_q], wq_data[wq_head_q]};
        end else if (rd_pop) begin
            pipe_d[0] = '{1'b1, 1'b0, rq_addr[rq_head_q], '0};
        end
        for (int s = 1; s < LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end

        any_valid = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            any_valid = any_valid | pipe_q[s].valid;
        end

        last             = pipe_q[LATENCY-1];
        last_idx         = last.address[MEM_AW-1:0];
        wr_ret_ack_d     = last.valid && last.is_wr;
        rd_ret_ack_d     = last.valid && !last.is_wr;
        wr_ret_address_d = wr_ret_ack_d ? last.address : wr_ret_address_q;
        rd_ret_address_d = rd_ret_ack_d ? last.address : rd_ret_address_q;
        rd_ret_data_d    = rd_ret_ack_d ? mem[last_idx] : rd_ret_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_head_q        <= '0;
            wq_tail_q        <= '0;
            wq_count_q       <= '0;
            rq_head_q        <= '0;
            rq_tail_q        <= '0;
            rq_count_q       <= '0;
            pipe_q           <= '{default: '0};
            wr_ret_ack_q     <= 1'b0;
            rd_ret_ack_q     <= 1'b0;
            wr_ret_address_q <= '0;
            rd_ret_address_q <= '0;
            rd_ret_data_q    <= '0;
        end else begin
            wq_head_q        <= wq_head_d;
            wq_tail_q        <= wq_tail_d;
            wq_count_q       <= wq_count_d;
            rq_head_q        <= rq_head_d;
            rq_tail_q        <= rq_tail_d;
            rq_count_q       <= rq_count_d;
            pipe_q           <= pipe_d;
            wr_ret_ack_q     <= wr_ret_ack_d;
            rd_ret_ack_q     <= rd_ret_ack_d;
            wr_ret_address_q <= wr_ret_address_d;
            rd_ret_address_q <= rd_ret_address_d;
            rd_ret_data_q    <= rd_ret_data_d;
        end
    end

    // NOTE: FIFO payloads and the array are plain storage with no reset; committed data survives reset.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wq_addr[wq_tail_q] <= bus.wr_address;
            wq_data[wq_tail_q] <= bus.wr_data;
        end
        if (rd_push) begin
            rq_addr[rq_tail_q] <= bus.rd_address;
        end
        if (wr_ret_ack_d) begin
            mem[last_idx] <= last.data;
        end
    end

    assign bus.wr_ready       = wr_ready;
    assign bus.rd_ready       = rd_ready;
    assign bus.wr_ret_ack     = wr_ret_ack_q;
    assign bus.wr_ret_address = wr_ret_address_q;
    assign bus.rd_ret_ack     = rd_ret_ack_q;
    assign bus.rd_ret_address = rd_ret_address_q;
    assign bus.rd_ret_data    = rd_ret_data_q;
    assign bus.busy           = wr_nonempty || rd_nonempty || any_valid;
endmodule
